io_bus_master: RTL and testbench
================================

Name: io_bus_master

Overview:
- Hardware sequencer that acts as initiator on the CPU-side data bus, in place of the processor's load/store path.
- Drives write_EN/data_addr/write_data and samples read_data, so a data-memory/IO decoder can be exercised and run without software.
- On start it performs one complete memory-mapped IO transaction in order: poll the input-ready status, read the switches, compute a result, poll the output-ready status, write the LED register.
- Used for bring-up of the IO path and as a self-test master on the board.

Parameters:
- POLL_TIMEOUT, 1024, maximum cycles spent in either poll state before aborting with error.
- DATA_W, 32, data bus width (fixed at 32 in this design; parameter exists for bench reuse).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request one transaction; sampled only in IDLE.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a transaction ends (success or error).
- error  output  1  high with done when the transaction aborted on timeout; 0 otherwise.
- result  output  12  last value written to LEDs; held until the next successful write.
- write_EN  output  1  bus write enable.
- data_addr  output  32  bus address.
- write_data  output  32  bus write data.
- read_data  input  32  bus read data; combinational, valid in the same cycle as data_addr.

Behaviour:
- Reset values: state IDLE; busy 0, done 0, error 0, result 0, write_EN 0, data_addr 0, write_data 0; poll counter 0; switch capture register 0.
- Bus outputs are Moore (decoded from state only); write_EN is never high outside WRITE_LED.
- Address map (io_bus_pkg constants):
  - STATUS_ADDR 0x0000_0080: bit0 = LED ready, bit1 = switch ready.
  - LED_ADDR 0x0000_0084.
  - SWITCH_ADDR 0x0000_0088: switch value on bits [15:0].
- All addresses have bit7 set and therefore decode to the IO port.
- States and transitions:
  - IDLE: bus idle. If start, go to POLL_IN and clear the counter. Otherwise stay.
  - POLL_IN: addr = STATUS_ADDR, read. If read_data[1], go to READ_SW. Else if counter == POLL_TIMEOUT-1, go to ABORT. Else increment the counter.
  - READ_SW: addr = SWITCH_ADDR, read; capture read_data[15:0] at the edge. Go to POLL_OUT and clear the counter.
  - POLL_OUT: addr = STATUS_ADDR, read. If read_data[0], go to WRITE_LED. Timeout as in POLL_IN.
  - WRITE_LED: write_EN = 1, addr = LED_ADDR, write_data = {20'b0, sum}.
    - sum = {3'b0, sw[15:8]} + {3'b0, sw[7:0]} (9-bit sum zero-extended to 12; max 0x1FE, no overflow).
    - result <= sum at the edge. Go to FINISH.
  - FINISH: done = 1, error = 0. Go to IDLE.
  - ABORT: done = 1, error = 1; result unchanged. Go to IDLE.
- Latency: with both status bits already set, start seen in IDLE gives done 5 cycles later (IDLE→POLL_IN→READ_SW→POLL_OUT→WRITE_LED→FINISH). Exactly one bus write per successful transaction.
- start while busy: ignored (no queueing). start in the FINISH/ABORT cycle: ignored. start held high: a new transaction begins on the cycle after the return to IDLE.
- Status bit toggling while in READ_SW: no effect; status is checked only in the poll states.
- Timeout: exactly POLL_TIMEOUT cycles in a poll state without the ready bit, then ABORT. The ready bit arriving in the final counted cycle still wins.
- rst mid-transaction: next edge forces IDLE with all outputs at reset values; a pending write is never issued after the reset edge; result cleared to 0.
- Counter width: $clog2(POLL_TIMEOUT); it never wraps.

Decomposition:
- Package io_bus_pkg:
  - state enum typedef (IDLE, POLL_IN, READ_SW, POLL_OUT, WRITE_LED, FINISH, ABORT);
  - STATUS_ADDR, LED_ADDR, SWITCH_ADDR;
  - status bit indices LED_RDY_BIT = 0, SW_RDY_BIT = 1.
- One sub-module: poll_timer (load-clear, enable, expire flag at POLL_TIMEOUT-1), shared by both poll states.

Test Plan:
- Reset then start with status = 0x3, switch = 0x1234 → exactly one write: addr 0x84, data 0x046; done at cycle 5; error 0; result 0x046.
- switch = 0xFFFF, status ready → write_data 0x1FE, result 0x1FE, no truncation.
- status bit1 held 0 for 10 cycles, then 1 → data_addr stays 0x80 for 11 cycles, then 0x88; done 15 cycles after start.
- status held 0, POLL_TIMEOUT = 16 → ABORT after 16 POLL_IN cycles: done = 1, error = 1, write_EN never asserted, result keeps its prior value.
- rst asserted in the POLL_OUT cycle → next cycle state IDLE, all outputs 0, no write to 0x84 observed.
- start pulsed again while busy → ignored, single done; start held high → back-to-back transactions separated by one IDLE cycle.

Source files
------------

// File: rtl/io_bus_pkg.sv
// Shared definitions for the IO bus master: FSM states, IO address map and
// status register bit positions.
package io_bus_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    POLL_IN   = 3'd1,
    READ_SW   = 3'd2,
    POLL_OUT  = 3'd3,
    WRITE_LED = 3'd4,
    FINISH    = 3'd5,
    ABORT     = 3'd6
  } state_e;

  localparam logic [31:0] STATUS_ADDR = 32'h0000_0080;
  localparam logic [31:0] LED_ADDR    = 32'h0000_0084;
  localparam logic [31:0] SWITCH_ADDR = 32'h0000_0088;

  localparam int unsigned LED_RDY_BIT = 0;
  localparam int unsigned SW_RDY_BIT  = 1;

  // Sum of the two switch bytes; 9 significant bits, so it cannot overflow 12.
  function automatic logic [11:0] sw_sum(input logic [15:0] sw);
    return {4'b0, sw[15:8]} + {4'b0, sw[7:0]};
  endfunction

endpackage

// File: rtl/poll_timer.sv
// Cycle counter for the poll states: cleared on entry, counts while waiting,
// flags the final allowed cycle so the FSM can abort.
module poll_timer #(
  parameter int unsigned POLL_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = (POLL_TIMEOUT > 1) ? $clog2(POLL_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(POLL_TIMEOUT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign expired = (count_q == LAST);

  // Saturates at LAST so the counter can never wrap.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en && !expired) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/io_bus_master.sv
// Bus initiator that runs one IO transaction per start: poll switch-ready,
// read switches, poll LED-ready, write the byte sum of the switches to the LEDs.
module io_bus_master
  import io_bus_pkg::*;
#(
  parameter int unsigned POLL_TIMEOUT = 1024,
  parameter int unsigned DATA_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [11:0]       result,
  output logic              write_EN,
  output logic [DATA_W-1:0] data_addr,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data
);

  state_e      state_q, state_d;
  logic [15:0] sw_q, sw_d;
  logic [11:0] result_q, result_d;
  logic [11:0] sum;
  logic        tmr_clear, tmr_en, tmr_expired;
  logic        unused_rd_hi;

  assign unused_rd_hi = ^read_data[DATA_W-1:16];
  assign sum          = sw_sum(sw_q);

  poll_timer #(
    .POLL_TIMEOUT(POLL_TIMEOUT)
  ) u_poll_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmr_clear),
    .en     (tmr_en),
    .expired(tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    sw_d      = sw_q;
    result_d  = result_q;
    tmr_clear = 1'b0;
    tmr_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        tmr_clear = 1'b1;
        if (start) state_d = POLL_IN;
      end
      // Ready is tested before expiry so a late ready bit still wins.
      POLL_IN: begin
        if (read_data[SW_RDY_BIT])  state_d = READ_SW;
        else if (tmr_expired)       state_d = ABORT;
        else                        tmr_en  = 1'b1;
      end
      READ_SW: begin
        sw_d      = read_data[15:0];
        tmr_clear = 1'b1;
        state_d   = POLL_OUT;
      end
      POLL_OUT: begin
        if (read_data[LED_RDY_BIT]) state_d = WRITE_LED;
        else if (tmr_expired)       state_d = ABORT;
        else                        tmr_en  = 1'b1;
      end
      WRITE_LED: begin
        result_d = sum;
        state_d  = FINISH;
      end
      FINISH:  state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sw_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      sw_q     <= sw_d;
      result_q <= result_d;
    end
  end

  // Bus and status outputs decode from state only.
  always_comb begin
    busy       = (state_q != IDLE);
    done       = (state_q == FINISH) || (state_q == ABORT);
    error      = (state_q == ABORT);
    write_EN   = (state_q == WRITE_LED);
    data_addr  = '0;
    write_data = '0;
    unique case (state_q)
      POLL_IN, POLL_OUT: data_addr = DATA_W'(STATUS_ADDR);
      READ_SW:           data_addr = DATA_W'(SWITCH_ADDR);
      WRITE_LED: begin
        data_addr  = DATA_W'(LED_ADDR);
        write_data = DATA_W'(sum);
      end
      default: ;
    endcase
  end

  assign result = result_q;

endmodule

// File: tb/tb_io_bus_master.sv
// Directed bench for io_bus_master with a behavioural IO slave on the bus.
module tb_io_bus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, error, write_EN;
  logic [11:0] result;
  logic [31:0] data_addr, write_data, read_data;

  logic [1:0]  status;
  logic [15:0] sw_val;

  int n_checks = 0;
  int n_err    = 0;
  int wr_cnt   = 0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;

  always #5 clk = ~clk;

  io_bus_master #(
    .POLL_TIMEOUT(16),
    .DATA_W(32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .result    (result),
    .write_EN  (write_EN),
    .data_addr (data_addr),
    .write_data(write_data),
    .read_data (read_data)
  );

  // IO slave: status and switch registers with junk in the unused upper bits.
  assign read_data = (data_addr == 32'h80) ? {30'h3000_0000, status} :
                     (data_addr == 32'h88) ? {16'hDEAD, sw_val} : 32'h0;

  always @(negedge clk) begin
    if (write_EN === 1'b1) begin
      wr_cnt  = wr_cnt + 1;
      wr_addr = data_addr;
      wr_data = write_data;
    end
  end

  typedef struct {
    logic [15:0] sw;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Pulses start for one cycle; lat counts negedges until done (1 = first busy cycle).
  task automatic do_txn(output int lat);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // As do_txn, but forces both status bits ready at negedge set_cyc and
  // records the first cycle the switch register is addressed.
  task automatic run_late(input int set_cyc, output int lat, output int first88);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    first88 = 0;
    while (lat < 60) begin
      if (data_addr == 32'h88 && first88 == 0) first88 = lat;
      if (done === 1'b1) break;
      if (lat == set_cyc) status = 2'b11;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, first88, w0, ndone, d1, d2;

    vecs[0] = '{16'h1234, 32'h046};
    vecs[1] = '{16'hFFFF, 32'h1FE};
    vecs[2] = '{16'h0000, 32'h000};
    vecs[3] = '{16'h00FF, 32'h0FF};
    vecs[4] = '{16'hFF00, 32'h0FF};
    vecs[5] = '{16'h8001, 32'h081};

    rst = 1'b1; start = 1'b0; status = 2'b00; sw_val = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",  {31'b0, busy},     32'h0);
    check("rst_done",  {31'b0, done},     32'h0);
    check("rst_error", {31'b0, error},    32'h0);
    check("rst_wen",   {31'b0, write_EN}, 32'h0);
    check("rst_addr",  data_addr,         32'h0);
    check("rst_wdata", write_data,        32'h0);
    check("rst_result",{20'b0, result},   32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      sw_val = vecs[i].sw;
      status = 2'b11;
      w0 = wr_cnt;
      do_txn(lat);
      check($sformatf("vec%0d_lat", i),    lat,                 32'd5);
      check($sformatf("vec%0d_err", i),    {31'b0, error},      32'h0);
      check($sformatf("vec%0d_nwr", i),    wr_cnt - w0,         32'd1);
      check($sformatf("vec%0d_waddr", i),  wr_addr,             32'h84);
      check($sformatf("vec%0d_wdata", i),  wr_data,             vecs[i].exp_data);
      check($sformatf("vec%0d_result", i), {20'b0, result},     vecs[i].exp_data);
      @(negedge clk);
      check($sformatf("vec%0d_idle", i),   {31'b0, busy},       32'h0);
    end

    // Switch ready arrives after 10 polled cycles.
    status = 2'b01; sw_val = 16'h0102;
    run_late(11, lat, first88);
    check("slow_first88", first88,        32'd12);
    check("slow_lat",     lat,            32'd15);
    check("slow_result",  {20'b0, result}, 32'h003);
    @(negedge clk);

    // Timeout in POLL_IN: result must survive.
    status = 2'b00; w0 = wr_cnt;
    do_txn(lat);
    check("to_in_lat",    lat,             32'd17);
    check("to_in_err",    {31'b0, error},  32'h1);
    check("to_in_nwr",    wr_cnt - w0,     32'd0);
    check("to_in_result", {20'b0, result}, 32'h003);
    @(negedge clk);

    // Timeout in POLL_OUT.
    status = 2'b10; sw_val = 16'h1111; w0 = wr_cnt;
    do_txn(lat);
    check("to_out_lat",   lat,             32'd19);
    check("to_out_err",   {31'b0, error},  32'h1);
    check("to_out_nwr",   wr_cnt - w0,     32'd0);
    @(negedge clk);

    // Ready in the final counted cycle still wins.
    status = 2'b00; sw_val = 16'h0A05;
    run_late(16, lat, first88);
    check("last_lat",    lat,             32'd20);
    check("last_err",    {31'b0, error},  32'h0);
    check("last_result", {20'b0, result}, 32'h00F);
    @(negedge clk);

    // Reset while in POLL_OUT with the LED about to become ready.
    status = 2'b10; sw_val = 16'h0303; w0 = wr_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("rstm_pollout_addr", data_addr, 32'h80);
    status = 2'b11; rst = 1'b1;
    @(negedge clk);
    check("rstm_busy",   {31'b0, busy},     32'h0);
    check("rstm_wen",    {31'b0, write_EN}, 32'h0);
    check("rstm_addr",   data_addr,         32'h0);
    check("rstm_result", {20'b0, result},   32'h0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("rstm_nwr",    wr_cnt - w0,       32'd0);

    // start while busy and in FINISH is ignored.
    status = 2'b11; sw_val = 16'h0101; ndone = 0;
    start = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 12; c++) begin
      if (done === 1'b1) ndone++;
      start = (c == 2 || c == 5);
      if (c == 7) check("busy_ign_idle", {31'b0, busy}, 32'h0);
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_ign_ndone", ndone, 32'd1);

    // start held: back-to-back transactions one IDLE cycle apart.
    d1 = 0; d2 = 0; w0 = wr_cnt;
    start = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 14; c++) begin
      if (done === 1'b1) begin
        if (d1 == 0) d1 = c;
        else if (d2 == 0) d2 = c;
      end
      if (c == 6) check("held_gap_idle", {31'b0, busy}, 32'h0);
      @(negedge clk);
    end
    start = 1'b0;
    check("held_done1", d1,          32'd5);
    check("held_done2", d2,          32'd11);
    check("held_nwr",   wr_cnt - w0, 32'd2);
    for (int c = 0; c < 30 && busy === 1'b1; c++) @(negedge clk);
    check("held_drain", {31'b0, busy}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
